// File: rtl/smc_stream.sv
// Streaming transistor evaluator: per-device ID or gm is insertion-sorted as it arrives,
// then a weighted sum of the TOPK largest or smallest results is emitted as a one-cycle pulse.
module smc_stream #(
    parameter int unsigned VW    = 3,
    parameter int unsigned N_DEV = 6,
    parameter int unsigned TOPK  = 3,
    parameter int unsigned OUT_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       mode,
    input  logic [VW-1:0]    W,
    input  logic [VW-1:0]    V_GS,
    input  logic [VW-1:0]    V_DS,
    output logic             out_valid,
    output logic [OUT_W-1:0] out_n
);

    localparam int unsigned VAL_W = 3 * VW;
    localparam int unsigned PW    = 4 * VW + 3;
    localparam int unsigned CW    = $clog2(N_DEV + 1);
    localparam int unsigned SW    = $clog2(N_DEV);
    localparam int unsigned IW    = (TOPK > 1) ? $clog2(TOPK) : 1;

    typedef enum logic [1:0] {StIdle, StLoad, StAcc, StOut} state_e;

    state_e           r_state, w_state_next;
    logic [CW-1:0]    r_cnt;
    logic [IW-1:0]    r_idx;
    logic [1:0]       r_mode;
    logic [OUT_W-1:0] r_acc;
    logic [VAL_W-1:0] r_s [N_DEV];

    logic [PW-1:0]    w_w, w_gs, w_ds, w_ov, w_id_num, w_gm_num;
    logic             w_id_mode, w_accept;
    logic [VAL_W-1:0] w_val;
    logic [VAL_W-1:0] w_base [N_DEV];
    logic [VAL_W-1:0] w_ins [N_DEV];
    logic [N_DEV-1:0] w_gt;
    logic [SW-1:0]    w_gidx;
    logic [OUT_W-1:0] w_wt, w_term;

    always_comb begin
        w_w      = PW'(W);
        w_gs     = PW'(V_GS);
        w_ds     = PW'(V_DS);
        w_ov     = w_gs - PW'(1);
        w_id_num = '0;
        w_gm_num = '0;
        if (V_GS != '0) begin
            if (w_ov > w_ds) begin
                w_id_num = w_w * (((w_ov * w_ds) << 1) - w_ds * w_ds);
                w_gm_num = (w_w * w_ds) << 1;
            end else begin
                w_id_num = w_w * w_ov * w_ov;
                w_gm_num = (w_w * w_ov) << 1;
            end
        end
    end

    // Beat 0 uses the live mode; later beats use the copy latched on beat 0.
    assign w_id_mode = (r_state == StIdle) ? mode[0] : r_mode[0];
    assign w_val     = VAL_W'((w_id_mode ? w_id_num : w_gm_num) / PW'(3));
    assign w_accept  = in_valid & in_ready;

    // Descending insertion; a fresh transaction starts from an all-zero array.
    always_comb begin
        for (int i = 0; i < N_DEV; i++) begin
            w_base[i] = (r_state == StIdle) ? '0 : r_s[i];
            w_gt[i]   = w_val > w_base[i];
        end
        w_ins[0] = w_gt[0] ? w_val : w_base[0];
        for (int i = 1; i < N_DEV; i++) begin
            if (!w_gt[i]) begin
                w_ins[i] = w_base[i];
            end else if (w_gt[i-1]) begin
                w_ins[i] = w_base[i-1];
            end else begin
                w_ins[i] = w_val;
            end
        end
    end

    assign w_gidx = r_mode[1] ? SW'(r_idx) : SW'(r_idx) + SW'(N_DEV - TOPK);
    assign w_wt   = r_mode[0] ? OUT_W'(TOPK) + OUT_W'(r_idx) : OUT_W'(1);
    assign w_term = OUT_W'(r_s[w_gidx]) * w_wt;

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        out_n        = '0;
        unique case (r_state)
            StIdle: begin
                in_ready = 1'b1;
                if (in_valid) w_state_next = (N_DEV == 1) ? StAcc : StLoad;
            end
            StLoad: begin
                in_ready = 1'b1;
                if (in_valid && r_cnt == CW'(N_DEV - 1)) w_state_next = StAcc;
            end
            StAcc: begin
                if (r_idx == IW'(TOPK - 1)) w_state_next = StOut;
            end
            StOut: begin
                out_valid    = 1'b1;
                out_n        = r_acc;
                w_state_next = StIdle;
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_mode  <= '0;
            r_acc   <= '0;
            for (int i = 0; i < N_DEV; i++) r_s[i] <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                for (int i = 0; i < N_DEV; i++) r_s[i] <= w_ins[i];
                if (r_state == StIdle) begin
                    r_mode <= mode;
                    r_cnt  <= CW'(1);
                    r_acc  <= '0;
                    r_idx  <= '0;
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end
            if (r_state == StAcc) begin
                r_acc <= r_acc + w_term;
                r_idx <= r_idx + IW'(1);
            end
        end
    end

endmodule

// File: tb/tb_smc_stream.sv
// Scoreboard bench for smc_stream: default instance (6 devices, top-3) and an
// 8-device, top-2 instance; expected sums come from constants or a reference model.
module tb_smc_stream;

    logic       clk = 1'b0;
    logic       rst, in_valid, sel;
    logic [1:0] mode;
    logic [2:0] W, V_GS, V_DS;
    logic       in_valid6, in_valid8, rdy6, rdy8, ov6, ov8;
    logic [9:0] on6;
    logic [11:0] on8;
    logic       in_ready_m, out_valid_m;
    logic [11:0] out_n_m;

    int checks = 0;
    int errors = 0;
    int exp_q[$];
    int dev_w[8], dev_g[8], dev_d[8];

    always #5 clk = ~clk;

    assign in_valid6   = in_valid & ~sel;
    assign in_valid8   = in_valid & sel;
    assign in_ready_m  = sel ? rdy8 : rdy6;
    assign out_valid_m = sel ? ov8 : ov6;
    assign out_n_m     = sel ? on8 : {2'b00, on6};

    smc_stream u_dut6 (
        .clk(clk), .rst(rst), .in_valid(in_valid6), .in_ready(rdy6), .mode(mode),
        .W(W), .V_GS(V_GS), .V_DS(V_DS), .out_valid(ov6), .out_n(on6)
    );

    smc_stream #(.VW(3), .N_DEV(8), .TOPK(2), .OUT_W(12)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(rdy8), .mode(mode),
        .W(W), .V_GS(V_GS), .V_DS(V_DS), .out_valid(ov8), .out_n(on8)
    );

    function automatic int dev_val(int w, int g, int d, bit id);
        int ov;
        if (g == 0) return 0;
        ov = g - 1;
        if (ov > d) return id ? w * (2 * ov * d - d * d) / 3 : 2 * w * d / 3;
        return id ? w * ov * ov / 3 : 2 * w * ov / 3;
    endfunction

    function automatic int model(int n, int topk, int outw, logic [1:0] md);
        int v[8];
        int t, g;
        int sum = 0;
        for (int i = 0; i < n; i++) v[i] = dev_val(dev_w[i], dev_g[i], dev_d[i], md[0]);
        for (int i = 0; i < n; i++)
            for (int j = 0; j < n - 1 - i; j++)
                if (v[j] < v[j+1]) begin t = v[j]; v[j] = v[j+1]; v[j+1] = t; end
        for (int i = 0; i < topk; i++) begin
            g = md[1] ? v[i] : v[n - topk + i];
            sum += (md[0] ? topk + i : 1) * g;
        end
        return sum % (1 << outw);
    endfunction

    function automatic void set_sat(int n);
        for (int i = 0; i < n; i++) begin
            dev_w[i] = 3; dev_g[i] = 2 + (i % 6); dev_d[i] = 7;
        end
    endfunction

    // Drives nbeats descriptors; returns #1 after the edge that accepted the last beat.
    task automatic send_txn(input int nbeats, input logic [1:0] md, input bit gaps,
                            input bit toggle);
        bit got;
        for (int b = 0; b < nbeats; b++) begin
            if (gaps) begin
                in_valid = 1'b0;
                repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            end
            in_valid = 1'b1;
            W = 3'(dev_w[b]); V_GS = 3'(dev_g[b]); V_DS = 3'(dev_d[b]);
            mode = (b == 0 || !toggle) ? md : 2'($urandom_range(0, 3));
            got = 1'b0;
            for (int t = 0; t < 20 && !got; t++) begin
                @(negedge clk);
                got = in_ready_m;
                @(posedge clk); #1;
            end
            if (!got) begin
                checks++; errors++;
                $display("FAIL accept_beat: beat %0d not accepted in 20 cycles, want accepted", b);
            end
        end
        in_valid = 1'b0;
    endtask

    // Cycle 1 is the cycle right after the last beat's edge.
    task automatic wait_result(input int k0, output bit seen, output int lat, output int val,
                               output bit one_cycle);
        seen = 0; lat = 0; val = 0; one_cycle = 0;
        for (int k = k0; k <= 40 && !seen; k++) begin
            if (out_valid_m) begin
                seen = 1; lat = k; val = int'(out_n_m);
            end else begin
                @(posedge clk); #1;
            end
        end
        if (seen) begin
            @(posedge clk); #1;
            one_cycle = !out_valid_m && out_n_m == 0 && in_ready_m;
        end
    endtask

    task automatic watch_no_pulse(input string name);
        bit pulsed = 0;
        repeat (12) begin
            if (out_valid_m) pulsed = 1;
            @(posedge clk); #1;
        end
        checks++;
        if (pulsed !== 1'b0) begin
            errors++; $display("FAIL %s: out_valid pulsed=%0b, want 0", name, pulsed);
        end
    endtask

    task automatic test_reset();
        sel = 0; in_valid = 0; mode = 0; W = 0; V_GS = 0; V_DS = 0;
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (rdy6 !== 1'b1 || rdy8 !== 1'b1) begin
            errors++; $display("FAIL reset_ready: in_ready=%b/%b, want 1/1", rdy6, rdy8);
        end
        checks++;
        if (ov6 !== 1'b0 || ov8 !== 1'b0 || on6 !== '0 || on8 !== '0) begin
            errors++;
            $display("FAIL reset_out: out_valid=%b/%b out_n=%0d/%0d, want 0", ov6, ov8, on6, on8);
        end
        rst = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_modes();
        int want[4] = '{12, 48, 30, 288};
        bit seen, oc;
        int lat, val, exp;
        sel = 0;
        set_sat(6);
        for (int m = 0; m < 4; m++) begin
            exp_q.push_back(want[m]);
            send_txn(6, 2'(m), 0, 0);
            wait_result(1, seen, lat, val, oc);
            exp = exp_q.pop_front();
            checks++;
            if (!seen || val !== exp) begin
                errors++; $display("FAIL modes m=%0d: out_n=%0d seen=%0b, want %0d", m, val, seen, exp);
            end
            checks++;
            if (lat !== 4 || !oc) begin
                errors++;
                $display("FAIL modes_timing m=%0d: latency=%0d single=%0b, want 4/1", m, lat, oc);
            end
        end
    endtask

    task automatic test_sort_order();
        int order[2][6] = '{'{7, 6, 5, 4, 3, 2}, '{4, 7, 2, 6, 3, 5}};
        bit seen, oc;
        int lat, val, exp;
        sel = 0;
        for (int o = 0; o < 2; o++) begin
            for (int i = 0; i < 6; i++) begin
                dev_w[i] = 3; dev_g[i] = order[o][i]; dev_d[i] = 7;
            end
            exp_q.push_back(288);
            send_txn(6, 2'd3, 0, 0);
            wait_result(1, seen, lat, val, oc);
            exp = exp_q.pop_front();
            checks++;
            if (!seen || val !== exp) begin
                errors++; $display("FAIL sort_order o=%0d: out_n=%0d, want %0d", o, val, exp);
            end
        end
    endtask

    task automatic test_triode();
        logic [1:0] md[3] = '{2'd3, 2'd2, 2'd1};
        int want[3] = '{12, 0, 7};
        bit seen, oc;
        int lat, val, exp;
        sel = 0;
        for (int c = 0; c < 3; c++) begin
            for (int i = 0; i < 6; i++) begin
                dev_w[i] = 1; dev_g[i] = 3; dev_d[i] = 1;
            end
            if (c == 2) dev_g[2] = 0;   // cutoff device must sort to the bottom
            exp_q.push_back(want[c]);
            send_txn(6, md[c], 0, 0);
            wait_result(1, seen, lat, val, oc);
            exp = exp_q.pop_front();
            checks++;
            if (!seen || val !== exp) begin
                errors++; $display("FAIL triode c=%0d: out_n=%0d, want %0d", c, val, exp);
            end
        end
    endtask

    task automatic test_max_gaps();
        bit seen, oc;
        int lat, val, exp;
        sel = 0;
        for (int i = 0; i < 6; i++) begin
            dev_w[i] = 7; dev_g[i] = 7; dev_d[i] = 7;
        end
        for (int g = 0; g < 3; g++) begin
            exp_q.push_back(1008);
            send_txn(6, 2'd3, g != 0, 0);
            wait_result(1, seen, lat, val, oc);
            exp = exp_q.pop_front();
            checks++;
            if (!seen || val !== exp || lat !== 4 || !oc) begin
                errors++;
                $display("FAIL max_gaps g=%0d: out_n=%0d lat=%0d single=%0b, want %0d/4/1",
                         g, val, lat, oc, exp);
            end
        end
    endtask

    task automatic test_reset_abort();
        bit seen, oc;
        int lat, val, exp;
        sel = 0;
        set_sat(6);
        send_txn(3, 2'd3, 0, 0);
        rst = 1; #2;
        checks++;
        if (in_ready_m !== 1'b1 || out_valid_m !== 1'b0) begin
            errors++;
            $display("FAIL abort_load_async: in_ready=%b out_valid=%b, want 1/0", in_ready_m, out_valid_m);
        end
        @(posedge clk); #1; rst = 0;
        watch_no_pulse("abort_load");
        exp_q.push_back(288);
        send_txn(6, 2'd3, 0, 0);
        wait_result(1, seen, lat, val, oc);
        exp = exp_q.pop_front();
        checks++;
        if (!seen || val !== exp) begin
            errors++; $display("FAIL after_load_abort: out_n=%0d, want %0d", val, exp);
        end
        // Abort mid-ACC while junk beats are being offered.
        send_txn(6, 2'd3, 0, 0);
        in_valid = 1; W = 7; V_GS = 7; V_DS = 7;
        @(posedge clk); #1;
        checks++;
        if (in_ready_m !== 1'b0) begin
            errors++; $display("FAIL acc_ready: in_ready=%b, want 0", in_ready_m);
        end
        rst = 1; #2; in_valid = 0;
        @(posedge clk); #1; rst = 0;
        watch_no_pulse("abort_acc");
        // Beats offered during ACC must not disturb the result.
        exp_q.push_back(288);
        send_txn(6, 2'd3, 0, 0);
        in_valid = 1; W = 7; V_GS = 7; V_DS = 7;
        repeat (2) begin @(posedge clk); #1; end
        in_valid = 0;
        wait_result(3, seen, lat, val, oc);
        exp = exp_q.pop_front();
        checks++;
        if (!seen || val !== exp || lat !== 4 || !oc) begin
            errors++;
            $display("FAIL ignored_beats: out_n=%0d lat=%0d single=%0b, want %0d/4/1", val, lat, oc, exp);
        end
    endtask

    task automatic test_param8();
        bit seen, oc;
        int lat, val, exp;
        sel = 1;
        set_sat(6);
        dev_w[6] = 3; dev_g[6] = 4; dev_d[6] = 7;
        dev_w[7] = 3; dev_g[7] = 6; dev_d[7] = 7;
        for (int m = 0; m < 6; m++) begin
            if (m >= 4)
                for (int i = 0; i < 8; i++) begin
                    dev_w[i] = $urandom_range(0, 7); dev_g[i] = $urandom_range(0, 7);
                    dev_d[i] = $urandom_range(0, 7);
                end
            exp_q.push_back(model(8, 2, 12, 2'(m)));
            send_txn(8, 2'(m), 0, 0);
            wait_result(1, seen, lat, val, oc);
            exp = exp_q.pop_front();
            checks++;
            if (!seen || val !== exp || lat !== 3 || !oc) begin
                errors++;
                $display("FAIL param8 m=%0d: out_n=%0d lat=%0d single=%0b, want %0d/3/1",
                         m, val, lat, oc, exp);
            end
        end
        sel = 0;
    endtask

    task automatic test_back_to_back();
        bit seen, oc;
        int lat, val, exp, n;
        logic [1:0] md;
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            n = s ? 8 : 6;
            for (int t = 0; t < 4; t++) begin
                for (int i = 0; i < 8; i++) begin
                    dev_w[i] = $urandom_range(0, 7); dev_g[i] = $urandom_range(0, 7);
                    dev_d[i] = $urandom_range(0, 7);
                end
                md = 2'(t);
                exp_q.push_back(s ? model(8, 2, 12, md) : model(6, 3, 10, md));
                send_txn(n, md, 0, 1);
                wait_result(1, seen, lat, val, oc);
                exp = exp_q.pop_front();
                checks++;
                if (!seen || val !== exp || !oc) begin
                    errors++;
                    $display("FAIL back_to_back s=%0d t=%0d: out_n=%0d single=%0b, want %0d/1",
                             s, t, val, oc, exp);
                end
            end
        end
        sel = 0;
    endtask

    initial begin
        test_reset();
        test_modes();
        test_sort_order();
        test_triode();
        test_max_gaps();
        test_reset_abort();
        test_param8();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
